// File: rtl/cgra_cfg_pkg.sv
// ----------------------------------------------------------------------------
// cgra_cfg_pkg
// Shared widths and the loader state type for the CGRA configuration path.
// A cell configuration is two stream words: the low word first, then the high word.
// ----------------------------------------------------------------------------
package cgra_cfg_pkg;

   localparam int WORD_WIDTH     = 32;
   localparam int CFG_WIDTH      = 2 * WORD_WIDTH;
   localparam int WORDS_PER_CELL = CFG_WIDTH / WORD_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      LOAD,
      DONE
   } loader_state_t;

endpackage

// File: rtl/cfg_word_assembler.sv
// ----------------------------------------------------------------------------
// cfg_word_assembler
// Pairs consecutive stream words into one cell configuration.
// The first word of a pair is held in a staging register. The second word
// completes the pair. In that same cycle the module presents {din, staging}
// and raises word_v, so the consumer can commit the pair on that clock edge.
//
// Ports
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : restarts pairing at the low word (new load)
//   xfer       : a stream word transfers this cycle
//   din        : stream word
//   word       : assembled configuration {din, staging}
//   word_v     : one-cycle strobe, high when xfer completes a pair
// ----------------------------------------------------------------------------
module cfg_word_assembler
   import cgra_cfg_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  xfer,
   input  logic [WORD_WIDTH-1:0] din,
   output logic [CFG_WIDTH-1:0]  word,
   output logic                  word_v
);

   logic [WORD_WIDTH-1:0] staging;
   logic                  phase;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         staging <= '0;
         phase   <= 1'b0;
      end else if (clear) begin
         staging <= '0;
         phase   <= 1'b0;
      end else if (xfer) begin
         if (!phase) begin
            staging <= din;
            phase   <= 1'b1;
         end else begin
            phase   <= 1'b0;
         end
      end
   end

   // The high word goes straight through, so the pair can be committed in the
   // cycle its second word arrives.
   assign word   = {din, staging};
   assign word_v = xfer & phase;

endmodule

// File: rtl/cgra_config_loader.sv
// ----------------------------------------------------------------------------
// cgra_config_loader
// Loads the 64-bit configuration register of every CGRA cell from a 32-bit
// valid/ready word stream. Cell 0 is loaded first. Within a cell the low word
// comes before the high word. While a load is in progress the loader holds the
// fabric-wide clear.
//
// Ports
//   clk, rst_n  : clock and asynchronous active-low reset
//   start       : begins a full load; honoured only in IDLE
//   cfg_din     : configuration word
//   cfg_din_v   : cfg_din valid
//   cfg_din_r   : loader ready (depends only on state, not on cfg_din_v)
//   config_bits : cell i at [i*CFG_WIDTH +: CFG_WIDTH]
//   cells_clr   : synchronous clear to all cells (CLEAR and LOAD)
//   busy        : high in CLEAR, LOAD and DONE
//   done        : one-cycle pulse after the final word is committed
// ----------------------------------------------------------------------------
module cgra_config_loader
   import cgra_cfg_pkg::*;
#(
   parameter int NUM_CELLS = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [WORD_WIDTH-1:0]          cfg_din,
   input  logic                           cfg_din_v,
   output logic                           cfg_din_r,
   output logic [NUM_CELLS*CFG_WIDTH-1:0] config_bits,
   output logic                           cells_clr,
   output logic                           busy,
   output logic                           done
);

   localparam int                IDX_W    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CELLS - 1);

   loader_state_t          state, state_nxt;
   logic [IDX_W-1:0]       idx;
   logic [CFG_WIDTH-1:0]   cfg_q [NUM_CELLS];
   logic [CFG_WIDTH-1:0]   pair_word;
   logic                   pair_v;
   logic                   start_ok;
   logic                   xfer;

   assign start_ok = (state == IDLE) && start;
   assign xfer     = cfg_din_v && cfg_din_r;

   cfg_word_assembler u_asm (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (start_ok),
      .xfer   (xfer),
      .din    (cfg_din),
      .word   (pair_word),
      .word_v (pair_v)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every signal driven here gets a default before the case statement,
   // so no path can leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cfg_din_r = 1'b0;
      cells_clr = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = CLEAR;
         end
         CLEAR: begin
            cells_clr = 1'b1;
            busy      = 1'b1;
            state_nxt = LOAD;
         end
         LOAD: begin
            cfg_din_r = 1'b1;
            cells_clr = 1'b1;
            busy      = 1'b1;
            if (pair_v && (idx == LAST_IDX)) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The index stops at the last cell. The last pair moves the FSM to DONE,
   // so a wrap could only come from a later load, and that load restarts the index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (start_ok) begin
         idx <= '0;
      end else if (pair_v && (idx != LAST_IDX)) begin
         idx <= idx + 1'b1;
      end
   end

   // NOTE: the configuration registers are reset on purpose. A load abandoned
   // by reset must not leave a partial configuration for the cells to decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CELLS; i++) cfg_q[i] <= '0;
      end else if (pair_v) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == IDX_W'(i)) cfg_q[i] <= pair_word;
         end
      end
   end

   for (genvar g = 0; g < NUM_CELLS; g++) begin : g_out
      assign config_bits[g*CFG_WIDTH +: CFG_WIDTH] = cfg_q[g];
   end

endmodule

// File: tb/tb_cgra_config_loader.sv
module tb_cgra_config_loader;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [31:0]  cfg_din;
   logic         cfg_din_v;
   logic         cfg_din_r;
   logic [127:0] config_bits;
   logic         cells_clr;
   logic         busy;
   logic         done;

   logic         s_start;
   logic [31:0]  s_din;
   logic         s_v;
   logic         s_rdy;
   logic [63:0]  s_cfg;
   logic         s_clr;
   logic         s_busy;
   logic         s_done;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   cgra_config_loader #(.NUM_CELLS(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cfg_din     (cfg_din),
      .cfg_din_v   (cfg_din_v),
      .cfg_din_r   (cfg_din_r),
      .config_bits (config_bits),
      .cells_clr   (cells_clr),
      .busy        (busy),
      .done        (done)
   );

   cgra_config_loader #(.NUM_CELLS(1)) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (s_start),
      .cfg_din     (s_din),
      .cfg_din_v   (s_v),
      .cfg_din_r   (s_rdy),
      .config_bits (s_cfg),
      .cells_clr   (s_clr),
      .busy        (s_busy),
      .done        (s_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one full load on the 2-cell instance. Stimulus advances through the
   // word list on each handshake; the measured timing is returned to the caller.
   task automatic do_load(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3,
                          input bit gaps, input bit mid_start,
                          output int done_cyc, output int clr_cyc,
                          output bit rdy_drop, output bit busy_after,
                          output bit done_after);
      logic [31:0] w [4];
      int k;
      bit rdy, v;
      w = '{w0, w1, w2, w3};
      k = 0; done_cyc = -1; clr_cyc = 0; rdy_drop = 1'b0;
      start = 1'b1; cfg_din = w[0]; cfg_din_v = !gaps;
      for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
         rdy = cfg_din_r; v = cfg_din_v;
         tick();
         if (rdy && v) k++;
         start     = mid_start && (cyc == 3);
         cfg_din   = (k < 4) ? w[k] : 32'h0;
         cfg_din_v = (k < 4) && (gaps ? (cyc % 3 == 2) : 1'b1);
         if (cells_clr) clr_cyc++;
         if (cells_clr && cyc >= 2 && !cfg_din_r) rdy_drop = 1'b1;
         if (done) done_cyc = cyc;
      end
      start = 1'b0; cfg_din_v = 1'b0;
      tick();
      busy_after = busy;
      done_after = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; cfg_din = '0; cfg_din_v = 1'b0;
      s_start = 1'b0; s_din = '0; s_v = 1'b0;
      #12;
      total++; if (config_bits !== 128'h0) $display("FAIL reset_cfg got=%h exp=0", config_bits); else passed++;
      total++; if ({cfg_din_r, cells_clr, busy, done} !== 4'b0000)
         $display("FAIL reset_ctl got=%b exp=0000", {cfg_din_r, cells_clr, busy, done}); else passed++;
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic check_load(input string name, input logic [127:0] exp_cfg,
                             input int exp_done, input int exp_clr,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3,
                             input bit gaps, input bit mid_start);
      int dc, cc; bit rd, ba, da;
      do_load(w0, w1, w2, w3, gaps, mid_start, dc, cc, rd, ba, da);
      total++; if (config_bits !== exp_cfg) $display("FAIL %s_cfg got=%h exp=%h", name, config_bits, exp_cfg); else passed++;
      total++; if (dc !== exp_done) $display("FAIL %s_done_cycle got=%0d exp=%0d", name, dc, exp_done); else passed++;
      total++; if (cc !== exp_clr) $display("FAIL %s_clr_cycles got=%0d exp=%0d", name, cc, exp_clr); else passed++;
      total++; if (rd !== 1'b0) $display("FAIL %s_ready_drop got=%b exp=0", name, rd); else passed++;
      total++; if ({ba, da} !== 2'b00) $display("FAIL %s_after_done busy,done got=%b exp=00", name, {ba, da}); else passed++;
   endtask

   task automatic test_basic();
      check_load("basic", 128'h44444444_33333333_22222222_11111111, 6, 5,
                 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b0);
   endtask

   task automatic test_idle_stream();
      int rdy_seen = 0;
      cfg_din = 32'hDEADBEEF; cfg_din_v = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cfg_din_r || busy) rdy_seen++;
      end
      cfg_din_v = 1'b0;
      total++; if (rdy_seen !== 0) $display("FAIL idle_ready got=%0d cycles exp=0", rdy_seen); else passed++;
      total++; if (config_bits !== 128'h44444444_33333333_22222222_11111111)
         $display("FAIL idle_cfg got=%h exp=4444444433333333_2222222211111111", config_bits); else passed++;
   endtask

   task automatic test_reload();
      check_load("load_a", {4{32'hAAAAAAAA}}, 6, 5,
                 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 1'b0);
      repeat (3) tick();
      total++; if (config_bits !== {4{32'hAAAAAAAA}}) $display("FAIL hold_a got=%h exp=AAAA..", config_bits); else passed++;
      check_load("load_b", {4{32'h55555555}}, 6, 5,
                 32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      check_load("gaps", 128'h44444444_33333333_22222222_11111111, 12, 11,
                 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b1, 1'b0);
   endtask

   task automatic test_mid_start();
      check_load("mid_start", 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001, 6, 5,
                 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_load();
      start = 1'b1; cfg_din = 32'h0BAD0001; cfg_din_v = 1'b1;
      tick(); start = 1'b0;          // CLEAR
      tick();                        // LOAD, low word of cell 0 presented
      tick(); cfg_din = 32'h0BAD0002; // low word accepted
      tick(); cfg_din = 32'h0BAD0003; // cell 0 committed
      total++; if (config_bits[63:0] !== 64'h0BAD0002_0BAD0001)
         $display("FAIL rml_cell0 got=%h exp=0BAD00020BAD0001", config_bits[63:0]); else passed++;
      tick();                        // cell 1 low word accepted
      rst_n = 1'b0;
      #1;
      total++; if (config_bits !== 128'h0) $display("FAIL rml_cfg got=%h exp=0", config_bits); else passed++;
      total++; if ({cfg_din_r, cells_clr, busy, done} !== 4'b0000)
         $display("FAIL rml_ctl got=%b exp=0000", {cfg_din_r, cells_clr, busy, done}); else passed++;
      @(negedge clk); rst_n = 1'b1;
      tick(); tick();
      total++; if ({cfg_din_r, busy} !== 2'b00) $display("FAIL rml_no_resume got=%b exp=00", {cfg_din_r, busy}); else passed++;
      cfg_din_v = 1'b0;
      check_load("after_rst", 128'h44444444_33333333_22222222_11111111, 6, 5,
                 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b0);
   endtask

   task automatic test_single_cell();
      int k = 0;
      int dc = -1;
      bit rdy, v;
      s_start = 1'b1; s_din = 32'h0; s_v = 1'b1;
      for (int cyc = 1; cyc <= 20 && dc < 0; cyc++) begin
         rdy = s_rdy; v = s_v;
         tick();
         if (rdy && v) k++;
         s_start = 1'b0;
         s_din   = (k == 0) ? 32'h0 : 32'hFFFFFFFF;
         s_v     = (k < 2);
         if (s_done) dc = cyc;
      end
      s_v = 1'b0;
      total++; if (s_cfg !== 64'hFFFFFFFF_00000000) $display("FAIL one_cell_cfg got=%h exp=FFFFFFFF00000000", s_cfg); else passed++;
      total++; if (dc !== 4) $display("FAIL one_cell_done_cycle got=%0d exp=4", dc); else passed++;
      tick();
      total++; if ({s_busy, s_done, s_clr} !== 3'b000) $display("FAIL one_cell_after got=%b exp=000", {s_busy, s_done, s_clr}); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_idle_stream();
      test_reload();
      test_backpressure();
      test_mid_start();
      test_reset_mid_load();
      test_single_cell();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cgra_config_loader.md
Name: cgra_config_loader

Overview:
- Producer end of the per-cell `config_bits` interface: fills the 64-bit configuration registers that every processing cell decodes.
- Consumes a 32-bit word stream over valid/ready from the host/DMA side and assembles word pairs into per-cell 64-bit configurations.
- Drives a fabric-wide `clr` while loading, so cell elastic buffers and FU state start clean.
- Sits at CGRA top level, between the bus/DMA slave and the cell array.

Parameters:
- NUM_CELLS, 16, number of processing cells configured per load (>=1).
- CFG_WIDTH, 64, configuration bits per cell; fixed at 2*WORD_WIDTH.
- WORD_WIDTH, 32, width of the incoming configuration stream.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a full load; honoured only in IDLE.
- cfg_din  input  WORD_WIDTH  configuration word.
- cfg_din_v  input  1  cfg_din valid.
- cfg_din_r  output  1  loader ready for cfg_din.
- config_bits  output  NUM_CELLS*CFG_WIDTH  concatenated cell configs; cell i at [i*CFG_WIDTH +: CFG_WIDTH].
- cells_clr  output  1  synchronous clear to all cells.
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- done  output  1  one-cycle pulse when the last word is committed.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all config_bits=0; staging register=0; cell index=0; word phase=0.
  - cfg_din_r=0, cells_clr=0, busy=0, done=0.
- State machine IDLE -> CLEAR -> LOAD -> DONE -> IDLE.
  - IDLE: cfg_din_r=0; stream words are never consumed. start=1 -> CLEAR; index and phase cleared.
  - CLEAR: exactly one cycle; cells_clr=1, busy=1, cfg_din_r=0; -> LOAD.
  - LOAD: cfg_din_r=1, cells_clr=1, busy=1. A word transfers when cfg_din_v & cfg_din_r.
  - DONE: one cycle; done=1, busy=1, cells_clr=0, cfg_din_r=0; -> IDLE.
- Word order in LOAD:
  - Cell 0 first.
  - Within a cell, the low word (bits 31:0) comes first, then the high word (bits 63:32).
  - Phase 0 transfer: word stored in staging; phase<=1.
  - Phase 1 transfer: config_bits[idx] <= {cfg_din, staging} at that clock edge; phase<=0; idx<=idx+1.
- Termination: the phase-1 transfer with idx==NUM_CELLS-1 -> DONE. idx does not wrap inside a load.
- Configuration outputs:
  - Untouched cells keep their previous value; registers are overwritten only by a new load.
  - Values persist through IDLE.
- Valid/ready rules:
  - Valid low in LOAD stalls the loader with no state change.
  - cfg_din_r does not depend combinationally on cfg_din_v.
- Latency: done asserts the cycle after the final transfer. Minimum load time is 2*NUM_CELLS+2 cycles from start.
- Boundary conditions:
  - start outside IDLE is ignored.
  - start and cfg_din_v high together in IDLE: no word consumed that cycle.
  - Reset mid-load: cells already written return to 0; load is abandoned and not resumed.
  - cells_clr deasserts in DONE, so cells see final configs with clr=0 from that cycle.

Decomposition:
- Package cgra_cfg_pkg:
  - CFG_WIDTH, WORD_WIDTH, WORDS_PER_CELL=CFG_WIDTH/WORD_WIDTH.
  - loader_state_t enum {IDLE, CLEAR, LOAD, DONE}.
- Sub-module cfg_word_assembler:
  - Holds the staging register and phase bit.
  - Emits a 64-bit word and a one-cycle word_v on each completed pair.
  - The top level owns the FSM, the cell index and the register array.

Test Plan:
- Basic load, NUM_CELLS=2, cfg_din_v held 1: start, then words 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> cell0=0x2222222211111111, cell1=0x4444444433333333; cells_clr high for exactly 5 cycles (CLEAR + 4 LOAD); done pulses on cycle 6 after start; busy low the next cycle.
- Backpressure/gaps: cfg_din_v toggled 1,0,0,1,... -> same final values as the basic load; no word duplicated or dropped; cfg_din_r stays 1 throughout LOAD.
- Ignored start and stream, with cfg_din_v=1 and 0xDEADBEEF in IDLE and no start for 10 cycles -> cfg_din_r=0, config_bits unchanged. Start pulsed again mid-LOAD -> no restart; final values correct.
- Reset mid-load: assert rst_n=0 after cell0 is committed and cell1's low word is accepted -> all config_bits=0, state IDLE, busy=0. A fresh load then completes normally.
- Reload overwrite: load A (all cells 0xAAAAAAAA_AAAAAAAA), then load B (0x5555...) -> after the second done every cell holds B. Between the two loads, outputs hold A while IDLE.
- NUM_CELLS=1 corner: two words 0x0, 0xFFFFFFFF -> config_bits=0xFFFFFFFF00000000; done 4 cycles after start.
